// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
package div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set; callers keep the low WIDTH bits,
    // which are correct for any WIDTH up to 32.
    function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
        if (neg) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract D, restore on borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] a_sh_s;
    logic [WIDTH:0] diff_s;

    // Trial subtraction on the WIDTH+1-bit accumulator; a set MSB means the result went negative.
    always_comb begin
        a_sh_s = {a_in, q_in[WIDTH-1]};
        diff_s = a_sh_s - {1'b0, d_in};
        q_out  = {q_in[WIDTH-2:0], ~diff_s[WIDTH]};
        if (diff_s[WIDTH]) begin
            // Restored value is below D, so it always fits in WIDTH bits.
            a_out = a_sh_s[WIDTH-1:0];
        end else begin
            a_out = diff_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/restoring_divider_n.sv
// Multi-cycle restoring divider, one quotient bit per cycle, optional signed mode.
module restoring_divider_n
    import div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Go,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             ResultValid,
    output logic             Busy,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_r;
    div_state_e       next_state_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             sq_r;
    logic             sr_r;
    logic             div0_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             valid_r;
    logic             busy_r;
    logic             dbz_r;

    logic             signed_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic             dvs_zero_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] quot_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_r),
        .q_in  (q_r),
        .d_in  (d_r),
        .a_out (a_next_s),
        .q_out (q_next_s)
    );

    // Operand magnitudes at acceptance and sign-corrected results at FIX.
    always_comb begin
        signed_s   = SIGNED_EN & Mode;
        dvd_neg_s  = signed_s & Dividend[WIDTH-1];
        dvs_neg_s  = signed_s & Divisor[WIDTH-1];
        dvs_zero_s = (Divisor == {WIDTH{1'b0}});
        dvd_mag_s  = WIDTH'(cond_negate(32'(Dividend), dvd_neg_s));
        dvs_mag_s  = WIDTH'(cond_negate(32'(Divisor), dvs_neg_s));
        if (div0_r) begin
            // Zero divisor: q_r still holds the raw dividend.
            quot_fix_s = {WIDTH{1'b1}};
            rem_fix_s  = q_r;
        end else begin
            quot_fix_s = WIDTH'(cond_negate(32'(q_r), sq_r));
            rem_fix_s  = WIDTH'(cond_negate(32'(a_r), sr_r));
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and Go acceptance.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Go) begin
                    accept_s     = 1'b1;
                    next_state_s = dvs_zero_s ? ST_FIX : ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_FIX;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FIX:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath: capture on acceptance, iterate in RUN, publish results in FIX.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            sq_r        <= 1'b0;
            sr_r        <= 1'b0;
            div0_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= CNT_W'(WIDTH - 1);
                        a_r     <= {WIDTH{1'b0}};
                        q_r     <= dvs_zero_s ? Dividend : dvd_mag_s;
                        d_r     <= dvs_mag_s;
                        sq_r    <= dvd_neg_s ^ dvs_neg_s;
                        sr_r    <= dvd_neg_s;
                        div0_r  <= dvs_zero_s;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b1;
                        dbz_r   <= 1'b0;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_r <= a_next_s;
                    q_r <= q_next_s;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_FIX: begin
                    quotient_r  <= quot_fix_s;
                    remainder_r <= rem_fix_s;
                    dbz_r       <= div0_r;
                    valid_r     <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient    = quotient_r;
    assign Remainder   = remainder_r;
    assign ResultValid = valid_r;
    assign Busy        = busy_r;
    assign DivByZero   = dbz_r;

endmodule

// File: tb/tb_restoring_divider_n.sv
// Scoreboard bench for restoring_divider_n: WIDTH=8 (signed capable) and WIDTH=4 instances.
module tb_restoring_divider_n;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp8_t;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp4_t;

    logic       clk;
    logic       rstn8, go8, mode8;
    logic [7:0] dvd8, dvs8, q8, r8;
    logic       valid8, busy8, dz8;
    logic       rstn4, go4, mode4;
    logic [3:0] dvd4, dvs4, q4, r4;
    logic       valid4, busy4, dz4;

    exp8_t exp8_q[$];
    exp4_t exp4_q[$];
    int    errors = 0;
    int    checks = 0;

    restoring_divider_n #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .Clock(clk), .Resetn(rstn8), .Go(go8), .Mode(mode8),
        .Dividend(dvd8), .Divisor(dvs8), .Quotient(q8), .Remainder(r8),
        .ResultValid(valid8), .Busy(busy8), .DivByZero(dz8)
    );

    restoring_divider_n #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .Clock(clk), .Resetn(rstn4), .Go(go4), .Mode(mode4),
        .Dividend(dvd4), .Divisor(dvs4), .Quotient(q4), .Remainder(r4),
        .ResultValid(valid4), .Busy(busy4), .DivByZero(dz4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp8_t model8(bit mode, logic [7:0] a, logic [7:0] b);
        exp8_t e;
        int    sa, sb;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1;
        end else if (!mode) begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            e.q = 8'(sa / sb); e.r = 8'(sa % sb); e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic exp4_t model4(logic [3:0] a, logic [3:0] b);
        exp4_t e;
        if (b == 4'd0) begin
            e.q = 4'hF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle Go to an idle WIDTH=8 unit; the edge inside is the acceptance edge.
    task automatic issue8(bit mode, logic [7:0] a, logic [7:0] b);
        mode8 = mode; dvd8 = a; dvs8 = b; go8 = 1'b1;
        exp8_q.push_back(model8(mode, a, b));
        tick();
        go8 = 1'b0;
    endtask

    task automatic issue4(logic [3:0] a, logic [3:0] b);
        mode4 = 1'b0; dvd4 = a; dvs4 = b; go4 = 1'b1;
        exp4_q.push_back(model4(a, b));
        tick();
        go4 = 1'b0;
    endtask

    // Counts edges until ResultValid (budgeted); edges=-1 on timeout.
    task automatic wait_valid8(output int edges, output bit busy_ok);
        edges = 0; busy_ok = 1'b1;
        while (!valid8 && edges < 40) begin
            if (!busy8) busy_ok = 1'b0;
            tick();
            edges++;
        end
        if (!valid8) edges = -1;
    endtask

    task automatic wait_valid4(output int edges);
        edges = 0;
        while (!valid4 && edges < 40) begin
            tick();
            edges++;
        end
        if (!valid4) edges = -1;
    endtask

    task automatic test_reset();
        checks++;
        if ({q8, r8, valid8, busy8, dz8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: got q=%h r=%h v=%b b=%b dz=%b, want all 0", q8, r8, valid8, busy8, dz8);
        end
        checks++;
        if ({q4, r4, valid4, busy4, dz4} !== 11'd0) begin
            errors++;
            $display("FAIL reset4: got q=%h r=%h v=%b b=%b dz=%b, want all 0", q4, r4, valid4, busy4, dz4);
        end
    endtask

    task automatic test_basic_unsigned();
        int    e;
        bit    bo;
        exp8_t x;
        issue8(1'b0, 8'd200, 8'd7);
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 9 || !bo || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL latency8: got edges=%0d busy_ok=%0b busy_end=%b, want 9/1/0", e, bo, busy8);
        end
        checks++;
        if (q8 !== 8'd28 || r8 !== 8'd4 || dz8 !== 1'b0) begin
            errors++;
            $display("FAIL div_200_7: got q=%0d r=%0d dz=%b, want 28 4 0", q8, r8, dz8);
        end
        // Outputs hold while idle even when operands change.
        dvd8 = 8'd3; dvs8 = 8'd1; mode8 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (q8 !== x.q || r8 !== x.r || valid8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL hold: got q=%h r=%h v=%b b=%b, want q=%h r=%h v=1 b=0", q8, r8, valid8, busy8, x.q, x.r);
        end
    endtask

    task automatic test_signed();
        int         e;
        bit         bo;
        exp8_t      x;
        logic [7:0] a, b;
        issue8(1'b1, 8'hF9, 8'h02);
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (q8 !== 8'hFD || r8 !== 8'hFF || q8 !== x.q || r8 !== x.r) begin
            errors++;
            $display("FAIL signed_m7_2: got q=%h r=%h, want FD FF", q8, r8);
        end
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (b == 8'd0) b = 8'h81;
            issue8(1'b1, a, b);
            wait_valid8(e, bo);
            x = exp8_q.pop_front();
            checks++;
            if (e !== 9 || q8 !== x.q || r8 !== x.r || dz8 !== x.dz) begin
                errors++;
                $display("FAIL signed_rand %h/%h: got q=%h r=%h dz=%b e=%0d, want q=%h r=%h dz=%b e=9",
                         a, b, q8, r8, dz8, e, x.q, x.r, x.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        int    e;
        bit    bo;
        exp8_t x;
        issue8(1'b0, 8'h5A, 8'h00);
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 1 || q8 !== 8'hFF || r8 !== 8'h5A || dz8 !== 1'b1 || x.dz !== 1'b1) begin
            errors++;
            $display("FAIL div0: got e=%0d q=%h r=%h dz=%b, want e=1 q=FF r=5A dz=1", e, q8, r8, dz8);
        end
        issue8(1'b0, 8'd10, 8'd3);
        checks++;
        if (dz8 !== 1'b0 || valid8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL div0_clear: got dz=%b v=%b b=%b after accept, want 0 0 1", dz8, valid8, busy8);
        end
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (q8 !== x.q || r8 !== x.r || dz8 !== 1'b0) begin
            errors++;
            $display("FAIL div_10_3: got q=%0d r=%0d dz=%b, want %0d %0d 0", q8, r8, dz8, x.q, x.r);
        end
    endtask

    task automatic test_overflow();
        int    e;
        bit    bo;
        exp8_t x;
        issue8(1'b1, 8'h80, 8'hFF);
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (q8 !== 8'h80 || r8 !== 8'h00 || dz8 !== 1'b0 || x.q !== 8'h80) begin
            errors++;
            $display("FAIL overflow: got q=%h r=%h dz=%b, want 80 00 0", q8, r8, dz8);
        end
    endtask

    task automatic test_go_midrun();
        int    e;
        bit    bo;
        exp8_t x;
        issue8(1'b0, 8'd200, 8'd7);
        tick(); tick(); tick();
        go8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd2; mode8 = 1'b1;
        tick(); tick();
        go8 = 1'b0;
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 4 || q8 !== x.q || r8 !== x.r || !bo) begin
            errors++;
            $display("FAIL go_midrun: got q=%0d r=%0d e=%0d, want q=%0d r=%0d e=4", q8, r8, e, x.q, x.r);
        end
        tick(); tick();
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b1 || q8 !== x.q) begin
            errors++;
            $display("FAIL go_midrun_idle: got b=%b v=%b q=%0d, want 0 1 %0d", busy8, valid8, q8, x.q);
        end
    endtask

    task automatic test_reset_midrun();
        int    e;
        bit    bo;
        exp8_t x;
        issue8(1'b0, 8'd250, 8'd9);
        tick(); tick(); tick();
        rstn8 = 1'b0;
        tick();
        rstn8 = 1'b1;
        exp8_q.delete();
        checks++;
        if ({q8, r8, valid8, busy8, dz8} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midrun: got q=%h r=%h v=%b b=%b dz=%b, want all 0", q8, r8, valid8, busy8, dz8);
        end
        issue8(1'b0, 8'd250, 8'd9);
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 9 || q8 !== x.q || r8 !== x.r || q8 !== 8'd27 || r8 !== 8'd7) begin
            errors++;
            $display("FAIL after_reset: got q=%0d r=%0d e=%0d, want 27 7 e=9", q8, r8, e);
        end
    endtask

    task automatic test_back_to_back();
        int    e;
        bit    bo;
        exp8_t x;
        mode8 = 1'b0; dvd8 = 8'd99; dvs8 = 8'd10; go8 = 1'b1;
        exp8_q.push_back(model8(1'b0, 8'd99, 8'd10));
        tick();
        mode8 = 1'b1; dvd8 = 8'hE0; dvs8 = 8'd3;
        exp8_q.push_back(model8(1'b1, 8'hE0, 8'd3));
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 9 || q8 !== x.q || r8 !== x.r) begin
            errors++;
            $display("FAIL b2b_first: got q=%0d r=%0d e=%0d, want %0d %0d e=9", q8, r8, e, x.q, x.r);
        end
        tick();
        go8 = 1'b0;
        checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got v=%b b=%b, want 0 1", valid8, busy8);
        end
        wait_valid8(e, bo);
        x = exp8_q.pop_front();
        checks++;
        if (e !== 9 || q8 !== x.q || r8 !== x.r) begin
            errors++;
            $display("FAIL b2b_second: got q=%h r=%h e=%0d, want %h %h e=9", q8, r8, e, x.q, x.r);
        end
    endtask

    task automatic test_w4();
        int    e;
        exp4_t x;
        issue4(4'd7, 4'd3);
        wait_valid4(e);
        x = exp4_q.pop_front();
        checks++;
        if (e !== 5 || q4 !== 4'd2 || r4 !== 4'd1 || q4 !== x.q) begin
            errors++;
            $display("FAIL w4_7_3: got q=%0d r=%0d e=%0d, want 2 1 e=5", q4, r4, e);
        end
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue4(4'(a), 4'(b));
                wait_valid4(e);
                x = exp4_q.pop_front();
                checks++;
                if (e < 0 || q4 !== x.q || r4 !== x.r || dz4 !== x.dz) begin
                    errors++;
                    $display("FAIL w4_sweep %0d/%0d: got q=%h r=%h dz=%b e=%0d, want q=%h r=%h dz=%b",
                             a, b, q4, r4, dz4, e, x.q, x.r, x.dz);
                end
            end
        end
    endtask

    initial begin
        rstn8 = 1'b0; go8 = 1'b0; mode8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
        rstn4 = 1'b0; go4 = 1'b0; mode4 = 1'b0; dvd4 = 4'd0; dvs4 = 4'd0;
        tick(); tick();
        test_reset();
        rstn8 = 1'b1; rstn4 = 1'b1;
        tick();
        test_basic_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_go_midrun();
        test_reset_midrun();
        test_back_to_back();
        test_w4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
